// File: rtl/elliptic_curve_structs.sv
// rtl/elliptic_curve_structs.sv - shared field parameters and types for the field-multiply path
//
// Purpose : holds the field width P_WIDTH, the curve parameter record
//           `params` (modulus p), the 2*P_WIDTH product type and the state
//           enum used by mod_reduce_serial.
// Ports   : none (package).
// Config  : MOD_REDUCE_RADIX4_EN selects the two-bits-per-cycle reducer in
//           mod_reduce_serial; nothing in this package depends on it.
package elliptic_curve_structs;

   localparam int P_WIDTH = 256;

   typedef struct packed {
      logic [P_WIDTH-1:0] p;
   } curve_params_t;

   // secp256k1 field prime
   localparam curve_params_t params = '{
      p: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
   };

   typedef logic [2*P_WIDTH-1:0] wide_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mod_reduce_state_t;

endpackage

// File: rtl/mod_reduce_step.sv
// rtl/mod_reduce_step.sv - one MSB-first shift-and-conditional-subtract reduction step
//
// Purpose : acc_next = (2*acc + bit_in) mod P_MOD, assuming acc < P_MOD.
// Ports   : acc      in  WIDTH  current remainder (< P_MOD)
//           bit_in   in  1      next operand bit, MSB first
//           acc_next out WIDTH  updated remainder (< P_MOD)
// Config  : MOD_REDUCE_RADIX4_EN (in mod_reduce_serial) chains two of these.
module mod_reduce_step
   import elliptic_curve_structs::*;
#(
   parameter int               WIDTH = P_WIDTH,
   parameter logic [WIDTH-1:0] P_MOD = WIDTH'(params.p)
) (
   input  logic [WIDTH-1:0] acc,
   input  logic             bit_in,
   output logic [WIDTH-1:0] acc_next
);

   // t can reach 2*P_MOD-1, so compare and subtract at WIDTH+1 bits and
   // only drop the top bit once the result is back below P_MOD.
   logic [WIDTH:0] t;
   logic [WIDTH:0] p_ext;

   assign t        = {acc, bit_in};
   assign p_ext    = {1'b0, P_MOD};
   assign acc_next = WIDTH'((t >= p_ext) ? (t - p_ext) : t);

endmodule

// File: rtl/mod_reduce_serial.sv
// rtl/mod_reduce_serial.sv - bit-serial reducer returning ab mod P_MOD
//
// Purpose : reduces a 2*WIDTH-bit product to a WIDTH-bit field element,
//           MSB first, one bit per cycle (two with MOD_REDUCE_RADIX4_EN).
// Ports   : clk     in  1        rising-edge clock
//           reset   in  1        asynchronous active-high reset
//           enable  in  1        level request, sampled in IDLE and DONE
//           ab      in  2*WIDTH  operand, captured on the accepting edge
//           r       out WIDTH    ab mod P_MOD, valid while done=1
//           done    out 1        result valid
// Config  : `define MOD_REDUCE_RADIX4_EN for two chained steps per cycle.
module mod_reduce_serial
   import elliptic_curve_structs::*;
#(
   parameter int               WIDTH = P_WIDTH,
   parameter logic [WIDTH-1:0] P_MOD = WIDTH'(params.p)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [2*WIDTH-1:0] ab,
   output logic [WIDTH-1:0]   r,
   output logic               done
);

   localparam int CW = $clog2(2 * WIDTH);
`ifdef MOD_REDUCE_RADIX4_EN
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
`else
   localparam logic [CW-1:0] CNT_INIT = CW'(2 * WIDTH - 1);
`endif

   mod_reduce_state_t  state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               fin_q, fin_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   step_acc;
   logic [2*WIDTH-1:0] shift_next;

`ifdef MOD_REDUCE_RADIX4_EN
   logic [WIDTH-1:0] mid_acc;

   mod_reduce_step #(.WIDTH(WIDTH), .P_MOD(P_MOD)) u_step0 (
      .acc      (acc_q),
      .bit_in   (shift_q[2*WIDTH-1]),
      .acc_next (mid_acc)
   );

   mod_reduce_step #(.WIDTH(WIDTH), .P_MOD(P_MOD)) u_step1 (
      .acc      (mid_acc),
      .bit_in   (shift_q[2*WIDTH-2]),
      .acc_next (step_acc)
   );

   assign shift_next = {shift_q[2*WIDTH-3:0], 2'b00};
`else
   mod_reduce_step #(.WIDTH(WIDTH), .P_MOD(P_MOD)) u_step0 (
      .acc      (acc_q),
      .bit_in   (shift_q[2*WIDTH-1]),
      .acc_next (step_acc)
   );

   assign shift_next = {shift_q[2*WIDTH-2:0], 1'b0};
`endif

   // State register and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         acc_q   <= '0;
         fin_q   <= 1'b0;
         r_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         fin_q   <= fin_d;
         r_q     <= r_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (fin_q)  state_d = DONE;
         DONE:    if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output logic. The last step only sets fin; the copy of
   // acc into r happens on the following edge, together with entering DONE.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      fin_d   = fin_q;
      r_d     = r_q;
      case (state_q)
         IDLE: begin
            if (enable) begin
               shift_d = ab;
               acc_d   = '0;
               cnt_d   = CNT_INIT;
               fin_d   = 1'b0;
            end
         end
         RUN: begin
            if (!fin_q) begin
               acc_d   = step_acc;
               shift_d = shift_next;
               if (cnt_q == '0) begin
                  fin_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end else begin
               r_d   = acc_q;
               fin_d = 1'b0;
            end
         end
         default: ;
      endcase
      done_d = (state_d == DONE);
   end

   assign r    = r_q;
   assign done = done_q;

endmodule

// File: tb/tb_mod_reduce_serial.sv
// tb/tb_mod_reduce_serial.sv - self-checking bench for mod_reduce_serial (W=8 and W=256)
module tb_mod_reduce_serial;
   import elliptic_curve_structs::*;

`ifdef MOD_REDUCE_RADIX4_EN
   localparam int LAT8   = 9;
   localparam int LAT256 = 257;
`else
   localparam int LAT8   = 17;
   localparam int LAT256 = 513;
`endif
   localparam int LIMIT = 700;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         en8;
   logic [15:0]  ab8;
   logic [7:0]   r8;
   logic         done8;
   logic         en256;
   logic [511:0] ab256;
   logic [255:0] r256;
   logic         done256;

   mod_reduce_serial #(.WIDTH(8), .P_MOD(8'd251)) dut8 (
      .clk    (clk),
      .reset  (rst),
      .enable (en8),
      .ab     (ab8),
      .r      (r8),
      .done   (done8)
   );

   mod_reduce_serial dut256 (
      .clk    (clk),
      .reset  (rst),
      .enable (en256),
      .ab     (ab256),
      .r      (r256),
      .done   (done256)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] ab;
      logic [7:0]  r;
   } vec8_t;

   vec8_t vecs [8];

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Runs one W=8 reduction. Without hold, enable drops and ab is scrambled
   // right after acceptance; the result must still be for the captured ab.
   task automatic run8(input logic [15:0] a, input logic [7:0] exp, input string nm, input bit hold);
      int n;
      @(negedge clk);
      ab8 = a;
      en8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
         en8 = 1'b0;
         ab8 = ~a;
      end
      n = 1;
      @(posedge clk); #1;
      while (!done8 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " latency"}, 512'(n), 512'(LAT8));
      chk({nm, " r"}, 512'(r8), 512'(exp));
      if (hold) begin
         repeat (3) begin
            @(posedge clk); #1;
            chk({nm, " done held"}, 512'(done8), 512'(1));
            chk({nm, " r held"}, 512'(r8), 512'(exp));
         end
         @(negedge clk);
         en8 = 1'b0;
      end
      @(posedge clk); #1;
      chk({nm, " done falls"}, 512'(done8), 512'(0));
   endtask

   task automatic run256(input logic [511:0] a, input string nm);
      int n;
      logic [511:0] exp;
      exp = a % {256'd0, params.p};
      @(negedge clk);
      ab256 = a;
      en256 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en256 = 1'b0;
      ab256 = ~a;
      n = 1;
      @(posedge clk); #1;
      while (!done256 && n < LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " latency"}, 512'(n), 512'(LAT256));
      chk({nm, " r"}, {256'd0, r256}, exp);
      @(posedge clk); #1;
      chk({nm, " done pulse"}, 512'(done256), 512'(0));
   endtask

   initial begin
      logic [511:0] wa, wb, wr;
      logic [15:0]  x;

      vecs[0] = '{16'hFFFF, 8'd24};
      vecs[1] = '{16'h0000, 8'd0};
      vecs[2] = '{16'h00FB, 8'd0};
      vecs[3] = '{16'h00FA, 8'd250};
      vecs[4] = '{16'hF619, 8'd0};   // 251*251
      vecs[5] = '{16'hF61A, 8'd1};
      vecs[6] = '{16'h0100, 8'd5};
      vecs[7] = '{16'h1234, 8'd142};

      rst   = 1'b1;
      en8   = 1'b0;
      ab8   = '0;
      en256 = 1'b0;
      ab256 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset r8", 512'(r8), 512'(0));
      chk("reset done8", 512'(done8), 512'(0));
      chk("reset r256", {256'd0, r256}, 512'd0);
      chk("reset done256", 512'(done256), 512'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         run8(vecs[i].ab, vecs[i].r, $sformatf("vec%0d", i), i == 0);

      for (int i = 0; i < 20; i++) begin
         x = 16'($urandom);
         run8(x, 8'(x % 16'd251), $sformatf("rand8_%0d", i), 1'b0);
      end

      wa = {256'd0, 256'ha061fedbd0f036687a3b46fadcfb7bc7a76ed8ea6dab88b26f1408590510cc1e};
      wb = {256'd0, 256'hdb26c704eefedca6f22c27666c22ed58703bcc4f56fd507907d37b085d79e091};
      run256(wa * wb, "w256 a*b");
      run256({512{1'b1}}, "w256 all-ones");
      for (int i = 0; i < 3; i++) begin
         wr = '0;
         for (int k = 0; k < 16; k++) wr = {wr[479:0], 32'($urandom)};
         run256(wr, $sformatf("rand256_%0d", i));
      end

      // Reset while dut8 sits in DONE and dut256 is about 100 cycles into RUN
      @(negedge clk);
      ab8   = 16'hFFFF;
      en8   = 1'b1;
      ab256 = wa * wb;
      en256 = 1'b1;
      repeat (101) @(posedge clk);
      @(negedge clk);
      chk("pre-reset done8", 512'(done8), 512'(1));
      rst = 1'b1;
      #1;
      chk("mid reset r8", 512'(r8), 512'(0));
      chk("mid reset done8", 512'(done8), 512'(0));
      chk("mid reset r256", {256'd0, r256}, 512'd0);
      chk("mid reset done256", 512'(done256), 512'(0));
      @(negedge clk);
      rst   = 1'b0;
      en8   = 1'b0;
      en256 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle after reset done256", 512'(done256), 512'(0));
      run8(16'hFFFF, 8'd24, "post-reset", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
